// File: rtl/bram_mcb_pkg.sv
// Shared types and constants for the block-RAM MCB port responder.
// Error-flag logic is enabled with BRAM_MCB_ERR_FLAGS_EN.
package bram_mcb_pkg;

    localparam int unsigned MEM_AW_DEF       = 12;
    localparam int unsigned CALIB_CYCLES_DEF = 64;
    localparam int unsigned DATA_FIFO_AW_DEF = 6;
    localparam int unsigned CMD_FIFO_AW_DEF  = 2;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned BL_W    = 6;
    localparam int unsigned INSTR_W = 3;
    localparam int unsigned ERR_W   = 4;

    localparam logic [INSTR_W-1:0] INSTR_WR = 3'b000;
    localparam logic [INSTR_W-1:0] INSTR_RD = 3'b001;

    localparam int unsigned ERR_BAD_INSTR   = 0;
    localparam int unsigned ERR_WR_UNDERRUN = 1;
    localparam int unsigned ERR_PUSH_FULL   = 2;
    localparam int unsigned ERR_POP_EMPTY   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } exec_state_t;

    // Command FIFO entry; rsvd pads the entry to the 41-bit command word.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [1:0]         rsvd;
        logic [ADDR_W-1:0]  byte_addr;
        logic [BL_W-1:0]    bl;
    } mcb_cmd_t;

    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } mcb_wr_t;

    localparam int unsigned CMD_W = $bits(mcb_cmd_t);
    localparam int unsigned WR_W  = $bits(mcb_wr_t);

endpackage

// File: rtl/bram_mcb_port_fifo.sv
// Synchronous first-word-fall-through FIFO with registered exact full/empty
// flags and an occupancy count; head reads as zero while empty.
module mcb_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && !r_empty;
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_empty ? '0 : r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/bram_mcb_port.sv
// Block-RAM stand-in for the Spartan-6 MCB user port 0 (cmd/wr/rd channels).
// Define BRAM_MCB_ERR_FLAGS_EN to implement the sticky err_flags register.
module bram_mcb_port
    import bram_mcb_pkg::*;
#(
    parameter int unsigned MEM_AW       = MEM_AW_DEF,
    parameter int unsigned CALIB_CYCLES = CALIB_CYCLES_DEF,
    parameter int unsigned DATA_FIFO_AW = DATA_FIFO_AW_DEF,
    parameter int unsigned CMD_FIFO_AW  = CMD_FIFO_AW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               calib_done,
    input  logic               p0_cmd_en,
    input  logic [INSTR_W-1:0] p0_cmd_instr,
    input  logic [ADDR_W-1:0]  p0_cmd_byte_addr,
    input  logic [BL_W-1:0]    p0_cmd_bl,
    output logic               p0_cmd_full,
    input  logic               p0_wr_en,
    input  logic [DATA_W-1:0]  p0_wr_data,
    input  logic [MASK_W-1:0]  p0_wr_mask,
    output logic               p0_wr_full,
    input  logic               p0_rd_en,
    output logic [DATA_W-1:0]  p0_rd_data,
    output logic               p0_rd_empty,
    output logic [ERR_W-1:0]   err_flags
);

    localparam int unsigned RD_CNT_W = DATA_FIFO_AW + 1;
    localparam int unsigned RD_DEPTH = 1 << DATA_FIFO_AW;
    localparam int unsigned CAL_W    = $clog2(CALIB_CYCLES + 1);

    // Calibration countdown, reloaded by every reset.
    logic [CAL_W-1:0] r_calib_cnt;
    logic             r_calib_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_calib_cnt  <= CAL_W'(CALIB_CYCLES);
            r_calib_done <= 1'(CALIB_CYCLES == 0);
        end else if (r_calib_cnt != '0) begin
            r_calib_cnt  <= r_calib_cnt - CAL_W'(1);
            r_calib_done <= (r_calib_cnt == CAL_W'(1));
        end
    end

    assign calib_done = r_calib_done;

    mcb_cmd_t              w_cmd_in;
    mcb_cmd_t              w_cmd_head;
    logic                  w_cmd_empty;
    logic                  w_cmd_pop;
    logic [CMD_FIFO_AW:0]  w_cmd_count;
    mcb_wr_t               w_wr_in;
    mcb_wr_t               w_wr_head;
    logic                  w_wr_empty;
    logic                  w_wr_pop;
    logic [DATA_FIFO_AW:0] w_wr_count;
    logic [RD_CNT_W-1:0]   w_rd_count;

    assign w_cmd_in = '{instr: p0_cmd_instr, rsvd: 2'b00,
                        byte_addr: p0_cmd_byte_addr, bl: p0_cmd_bl};
    assign w_wr_in  = '{mask: p0_wr_mask, data: p0_wr_data};

    mcb_sync_fifo #(.WIDTH(CMD_W), .AW(CMD_FIFO_AW)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (p0_cmd_en),
        .i_din   (w_cmd_in),
        .i_pop   (w_cmd_pop),
        .o_dout  (w_cmd_head),
        .o_full  (p0_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    mcb_sync_fifo #(.WIDTH(WR_W), .AW(DATA_FIFO_AW)) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (p0_wr_en),
        .i_din   (w_wr_in),
        .i_pop   (w_wr_pop),
        .o_dout  (w_wr_head),
        .o_full  (p0_wr_full),
        .o_empty (w_wr_empty),
        .o_count (w_wr_count)
    );

    exec_state_t         r_state;
    logic [MEM_AW-1:0]   r_addr;
    logic [BL_W-1:0]     r_left;
    logic                r_rd_vld;
    logic [DATA_W-1:0]   r_rd_word;
    logic [DATA_W-1:0]   r_mem [1 << MEM_AW];
    logic [RD_CNT_W-1:0] w_rd_free;
    logic [RD_CNT_W-1:0] w_rd_need;
    logic                w_head_ok;

    mcb_sync_fifo #(.WIDTH(DATA_W), .AW(DATA_FIFO_AW)) u_rd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_rd_vld),
        .i_din   (r_rd_word),
        .i_pop   (p0_rd_en),
        .o_dout  (p0_rd_data),
        .o_full  (),
        .o_empty (p0_rd_empty),
        .o_count (w_rd_count)
    );

    // A read is only started once the whole burst is guaranteed to fit.
    assign w_rd_free = RD_CNT_W'(RD_DEPTH) - w_rd_count;
    assign w_rd_need = RD_CNT_W'(w_cmd_head.bl) + RD_CNT_W'(1);
    assign w_head_ok = (w_cmd_head.instr != INSTR_RD) || (w_rd_free >= w_rd_need);
    assign w_cmd_pop = (r_state == ST_IDLE) && r_calib_done && !w_cmd_empty && w_head_ok;
    assign w_wr_pop  = (r_state == ST_WRITE) && !w_wr_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_left   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_vld <= 1'b0;
                    if (w_cmd_pop) begin
                        r_addr <= w_cmd_head.byte_addr[MEM_AW+1:2];
                        r_left <= w_cmd_head.bl;
                        case (w_cmd_head.instr)
                            INSTR_WR: r_state <= ST_WRITE;
                            INSTR_RD: r_state <= ST_READ;
                            default:  r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (w_wr_pop) begin
                        r_addr <= r_addr + MEM_AW'(1);
                        r_left <= r_left - BL_W'(1);
                        if (r_left == '0) r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    r_addr   <= r_addr + MEM_AW'(1);
                    r_left   <= r_left - BL_W'(1);
                    r_rd_vld <= 1'b1;
                    if (r_left == '0) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_rd_vld <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Backing array with byte-masked writes and one-cycle read latency.
    always_ff @(posedge clk) begin
        if (w_wr_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!w_wr_head.mask[b]) r_mem[r_addr][8*b +: 8] <= w_wr_head.data[8*b +: 8];
            end
        end
        if (r_state == ST_READ) r_rd_word <= r_mem[r_addr];
    end

`ifdef BRAM_MCB_ERR_FLAGS_EN
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_set;

    always_comb begin
        w_err_set                  = '0;
        w_err_set[ERR_BAD_INSTR]   = w_cmd_pop && (w_cmd_head.instr != INSTR_WR)
                                               && (w_cmd_head.instr != INSTR_RD);
        w_err_set[ERR_WR_UNDERRUN] = (r_state == ST_WRITE) && w_wr_empty;
        w_err_set[ERR_PUSH_FULL]   = (p0_cmd_en && p0_cmd_full) || (p0_wr_en && p0_wr_full);
        w_err_set[ERR_POP_EMPTY]   = p0_rd_en && p0_rd_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_err <= '0;
        else          r_err <= r_err | w_err_set;
    end

    assign err_flags = r_err;
`else
    assign err_flags = '0;
`endif

    logic w_unused;
    assign w_unused = ^{w_cmd_head.rsvd, w_cmd_head.byte_addr[1:0],
                        w_cmd_head.byte_addr[ADDR_W-1:MEM_AW+2], w_cmd_count, w_wr_count};

endmodule

// File: tb/tb_bram_mcb_port.sv
// Scoreboard bench for bram_mcb_port: directed bursts, mask, wrap,
// back-pressure, command-FIFO full and error flags (BRAM_MCB_ERR_FLAGS_EN aware).
module tb_bram_mcb_port;

`ifdef BRAM_MCB_ERR_FLAGS_EN
    localparam logic [3:0] ERR_EN = 4'hF;
`else
    localparam logic [3:0] ERR_EN = 4'h0;
`endif

    logic        clk;
    logic        reset_n;
    logic        calib_done;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [29:0] p0_cmd_byte_addr;
    logic [5:0]  p0_cmd_bl;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;
    logic [3:0]  err_flags;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];

    bram_mcb_port dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .calib_done       (calib_done),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_bl        (p0_cmd_bl),
        .p0_cmd_full      (p0_cmd_full),
        .p0_wr_en         (p0_wr_en),
        .p0_wr_data       (p0_wr_data),
        .p0_wr_mask       (p0_wr_mask),
        .p0_wr_full       (p0_wr_full),
        .p0_rd_en         (p0_rd_en),
        .p0_rd_data       (p0_rd_data),
        .p0_rd_empty      (p0_rd_empty),
        .err_flags        (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_data(input logic [31:0] d, input logic [3:0] m);
        p0_wr_en = 1'b1; p0_wr_data = d; p0_wr_mask = m;
        tick(1);
        p0_wr_en = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [29:0] addr, input logic [5:0] bl);
        p0_cmd_en = 1'b1; p0_cmd_instr = instr; p0_cmd_byte_addr = addr; p0_cmd_bl = bl;
        tick(1);
        p0_cmd_en = 1'b0;
    endtask

    task automatic pop_words(input int n);
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < n && guard < 2000) begin
            tick(1);
            if (!p0_rd_empty) begin
                p0_rd_en = 1'b1;
                got++;
            end else begin
                p0_rd_en = 1'b0;
            end
            guard++;
        end
        tick(1);
        p0_rd_en = 1'b0;
        chk("pop_words_count", 32'(got), 32'(n));
    endtask

    initial begin
        int k;
        checks = 0; failures = 0;
        clk = 1'b0; reset_n = 1'b0;
        p0_cmd_en = 1'b0; p0_cmd_instr = '0; p0_cmd_byte_addr = '0; p0_cmd_bl = '0;
        p0_wr_en = 1'b0; p0_wr_data = '0; p0_wr_mask = '0; p0_rd_en = 1'b0;

        // Read-data monitor: every accepted pop is checked against the queue head.
        fork
            forever begin
                @(negedge clk);
                if (p0_rd_en && !p0_rd_empty) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected: got %h with nothing expected", p0_rd_data);
                    end else begin
                        chk("sb_rd_data", p0_rd_data, exp_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_calib_done", 32'(calib_done), 32'd0);
        chk("rst_rd_empty",   32'(p0_rd_empty), 32'd1);
        chk("rst_rd_data",    p0_rd_data, 32'd0);
        chk("rst_err_flags",  32'(err_flags), 32'd0);
        chk("rst_cmd_full",   32'(p0_cmd_full), 32'd0);
        chk("rst_wr_full",    32'(p0_wr_full), 32'd0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            tick(1);
            chk("calib_done", 32'(calib_done), 32'(i >= 64));
            if (i < 64) chk("calib_rd_empty", 32'(p0_rd_empty), 32'd1);
        end

        // Write 0x00..0x1F at 0x200, then read back and time the first word.
        for (int i = 0; i < 32; i++) push_data(32'(i), 4'h0);
        push_cmd(3'b000, 30'h200, 6'd31);
        tick(40);
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(i));
        push_cmd(3'b001, 30'h200, 6'd31);
        k = 0;
        while (p0_rd_empty && k < 20) begin
            tick(1);
            k++;
        end
        chk("rd_first_latency", 32'(k), 32'd3);
        pop_words(32);
        chk("sb_drained_basic", 32'(exp_q.size()), 32'd0);

        // Byte mask.
        push_data(32'hFFFF_FFFF, 4'b0000);
        push_cmd(3'b000, 30'h0, 6'd0);
        push_data(32'h1234_5678, 4'b0101);
        push_cmd(3'b000, 30'h0, 6'd0);
        exp_q.push_back(32'h12FF_56FF);
        push_cmd(3'b001, 30'h0, 6'd0);
        tick(10);
        pop_words(1);

        // Address wrap: word 4094, 4095, 0, 1.
        for (int i = 0; i < 4; i++) push_data(32'hA0A0_0000 + 32'(i), 4'h0);
        push_cmd(3'b000, 30'h3FF8, 6'd3);
        exp_q.push_back(32'hA0A0_0002);
        exp_q.push_back(32'hA0A0_0003);
        push_cmd(3'b001, 30'h0, 6'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A0_0000 + 32'(i));
        push_cmd(3'b001, 30'h3FF8, 6'd3);
        tick(20);
        pop_words(6);
        chk("sb_drained_wrap", 32'(exp_q.size()), 32'd0);

        // Back-pressure: 40 words parked, a 32-word read must wait for 8 pops.
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(i));
        push_cmd(3'b001, 30'h200, 6'd31);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        push_cmd(3'b001, 30'h200, 6'd7);
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(i));
        push_cmd(3'b001, 30'h200, 6'd31);
        tick(100);
        chk("bp_rd_not_empty", 32'(p0_rd_empty), 32'd0);
        pop_words(7);
        tick(60);
        pop_words(1);
        tick(60);
        pop_words(64);
        chk("sb_drained_bp", 32'(exp_q.size()), 32'd0);
        chk("err_none_yet", 32'(err_flags), 32'd0);

        // Error flags and command FIFO full.
        push_cmd(3'b010, 30'h0, 6'd0);
        tick(5);
        chk("err_bad_instr", 32'(err_flags), 32'(4'b0001 & ERR_EN));
        p0_rd_en = 1'b1;
        tick(1);
        p0_rd_en = 1'b0;
        tick(1);
        chk("err_pop_empty", 32'(err_flags), 32'(4'b1001 & ERR_EN));
        for (int i = 0; i < 4; i++) push_data(32'hC0DE_0000 + 32'(i), 4'h0);
        push_cmd(3'b000, 30'h100, 6'd7);
        tick(10);
        chk("err_wr_underrun", 32'(err_flags), 32'(4'b1011 & ERR_EN));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i));
        push_cmd(3'b001, 30'h100, 6'd3);
        for (int i = 4; i < 8; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i));
        push_cmd(3'b001, 30'h110, 6'd3);
        exp_q.push_back(32'hC0DE_0000);
        push_cmd(3'b001, 30'h100, 6'd0);
        exp_q.push_back(32'hC0DE_0007);
        push_cmd(3'b001, 30'h11C, 6'd0);
        chk("cmd_full", 32'(p0_cmd_full), 32'd1);
        push_cmd(3'b001, 30'h104, 6'd0);
        chk("err_push_full", 32'(err_flags), 32'(4'b1111 & ERR_EN));
        chk("rd_empty_stalled", 32'(p0_rd_empty), 32'd1);
        for (int i = 4; i < 8; i++) push_data(32'hC0DE_0000 + 32'(i), 4'h0);
        tick(40);
        chk("cmd_not_full", 32'(p0_cmd_full), 32'd0);
        pop_words(10);
        tick(20);
        chk("sb_drained_err", 32'(exp_q.size()), 32'd0);
        chk("rd_empty_end", 32'(p0_rd_empty), 32'd1);

        // Reset mid-burst clears flags and restarts calibration.
        for (int i = 0; i < 2; i++) push_data(32'h5555_0000 + 32'(i), 4'h0);
        push_cmd(3'b000, 30'h400, 6'd7);
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("rst2_calib_done", 32'(calib_done), 32'd0);
        chk("rst2_err_flags",  32'(err_flags), 32'd0);
        chk("rst2_rd_empty",   32'(p0_rd_empty), 32'd1);
        chk("rst2_cmd_full",   32'(p0_cmd_full), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("rst2_calib_low", 32'(calib_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
